// File: rtl/sat_adjust_ramp_ctrl.sv
// Frame-synchronous ramp of the saturation-adjust word toward a host target; output moves one edge after an accepted EOF.
// Purely observational on the pixel stream: snoops valid/ready/user and never applies backpressure.
module sat_adjust_ramp_ctrl #(
    parameter int EOF_BIT = 1,
    parameter int TIMEOUT = 5_000_000,
    parameter int TO_W    = 23,
    parameter int FCNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_target,
    input  logic [6:0]        cfg_step,
    input  logic              cfg_enable,
    input  logic              mon_valid,
    input  logic              mon_ready,
    input  logic [7:0]        mon_user,
    output logic [7:0]        isp_adjustment,
    output logic              ramp_busy,
    output logic              timeout_pulse,
    output logic [FCNT_W-1:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RAMP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic signed [7:0]  cur_q, cur_d;
    logic signed [7:0]  tgt_q, tgt_d;
    logic [TO_W-1:0]    wd_q, wd_d;
    logic [7:0]         isp_q, isp_d;
    logic               busy_q, busy_d;
    logic               pulse_q, pulse_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

    logic               eof_evt;
    logic signed [7:0]  eff;
    logic signed [7:0]  tgt_mag;
    logic signed [8:0]  diff;
    logic [8:0]         diff_mag;
    logic signed [7:0]  stepped;
    logic [7:0]         cur_neg;

    assign eof_evt = mon_valid & mon_ready & mon_user[EOF_BIT];
    assign eff     = cfg_enable ? tgt_q : 8'sd0;
    assign tgt_mag = signed'({1'b0, cfg_target[6:0]});

    // 9-bit difference so that +127 - (-127) cannot wrap.
    assign diff     = {eff[7], eff} - {cur_q[7], cur_q};
    assign diff_mag = diff[8] ? 9'(-diff) : 9'(diff);

    always_comb begin
        stepped = eff;
        if (cfg_step != 7'd0 && diff_mag > {2'b00, cfg_step}) begin
            if (diff[8]) begin
                stepped = cur_q - signed'({1'b0, cfg_step});
            end else begin
                stepped = cur_q + signed'({1'b0, cfg_step});
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = cfg_we ? (cfg_target[7] ? tgt_mag : -tgt_mag) : tgt_q;
        wd_d    = '0;
        pulse_d = 1'b0;
        fcnt_d  = fcnt_q + {{(FCNT_W-1){1'b0}}, eof_evt};

        case (state_q)
            IDLE, HOLD: begin
                if (eff != cur_q) begin
                    state_d = RAMP;
                end else if (!cfg_enable && eff == 8'sd0) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            RAMP: begin
                // An EOF in the same cycle as watchdog expiry wins: normal step, no pulse.
                if (eof_evt) begin
                    cur_d = stepped;
                end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                    cur_d   = eff;
                    pulse_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
                if (cur_d == eff) begin
                    state_d = (!cfg_enable && eff == 8'sd0) ? IDLE : HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cur_neg = 8'(-cur_d);
        if (cur_d[7]) begin
            isp_d = {1'b0, cur_neg[6:0]};
        end else if (cur_d == 8'sd0) begin
            isp_d = 8'h00;
        end else begin
            isp_d = {1'b1, cur_d[6:0]};
        end
        busy_d = (state_d == RAMP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= 8'sd0;
            tgt_q   <= 8'sd0;
            wd_q    <= '0;
            isp_q   <= 8'h00;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            wd_q    <= wd_d;
            isp_q   <= isp_d;
            busy_q  <= busy_d;
            pulse_q <= pulse_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign isp_adjustment = isp_q;
    assign ramp_busy      = busy_q;
    assign timeout_pulse  = pulse_q;
    assign frame_count    = fcnt_q;

endmodule

// File: tb/tb_sat_adjust_ramp_ctrl.sv
// Bench for sat_adjust_ramp_ctrl: directed ramp scenarios followed by random traffic, all scored against a frame-level model.
module tb_sat_adjust_ramp_ctrl;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_target = 8'h00;
    logic [6:0]  cfg_step = 7'd0;
    logic        cfg_enable = 1'b0;
    logic        mon_valid = 1'b0;
    logic        mon_ready = 1'b1;
    logic [7:0]  mon_user = 8'h00;
    logic [7:0]  isp_adjustment;
    logic        ramp_busy;
    logic        timeout_pulse;
    logic [15:0] frame_count;

    typedef struct packed {
        logic [7:0]  isp;
        logic        busy;
        logic        pulse;
        logic [15:0] fc;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // model state: signed strength as plain integers
    int m_cur = 0;
    int m_tgt = 0;
    int m_wd  = 0;
    int m_fc  = 0;
    bit m_ramp = 1'b0;
    bit m_pulse = 1'b0;

    sat_adjust_ramp_ctrl #(
        .EOF_BIT(1), .TIMEOUT(TO), .TO_W(23), .FCNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_target(cfg_target), .cfg_step(cfg_step), .cfg_enable(cfg_enable),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_user(mon_user),
        .isp_adjustment(isp_adjustment), .ramp_busy(ramp_busy),
        .timeout_pulse(timeout_pulse), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic int conv(input logic [7:0] t);
        int m;
        m = int'(t[6:0]);
        return t[7] ? m : -m;
    endfunction

    function automatic logic [7:0] enc(input int c);
        if (c > 0) return {1'b1, 7'(c)};
        if (c < 0) return {1'b0, 7'(-c)};
        return 8'h00;
    endfunction

    function automatic int toward(input int c, input int e, input int s);
        int d, ad;
        d  = e - c;
        ad = (d < 0) ? -d : d;
        if (s == 0 || ad <= s) return e;
        return (d > 0) ? c + s : c - s;
    endfunction

    // Reference model: one update per clock using the inputs that edge sees.
    always @(posedge clk) begin
        obs_t e;
        int   eff;
        bit   eof;
        if (reset) begin
            m_cur = 0; m_tgt = 0; m_wd = 0; m_fc = 0; m_ramp = 1'b0; m_pulse = 1'b0;
        end else begin
            eof     = mon_valid && mon_ready && mon_user[1];
            eff     = cfg_enable ? m_tgt : 0;
            m_pulse = 1'b0;
            if (eof) m_fc = (m_fc + 1) % 65536;
            if (m_ramp) begin
                if (eof) begin
                    m_cur = toward(m_cur, eff, int'(cfg_step));
                    m_wd  = 0;
                end else if (m_wd == TO - 1) begin
                    m_cur   = eff;
                    m_pulse = 1'b1;
                    m_wd    = 0;
                end else begin
                    m_wd = m_wd + 1;
                end
                if (m_cur == eff) m_ramp = 1'b0;
            end else begin
                m_wd = 0;
                if (eff != m_cur) m_ramp = 1'b1;
            end
            if (cfg_we) m_tgt = conv(cfg_target);
        end
        e.isp   = enc(m_cur);
        e.busy  = m_ramp;
        e.pulse = m_pulse;
        e.fc    = 16'(m_fc);
        exp_q.push_back(e);
    end

    // Monitor: every edge presents a new output word; compare it shortly after.
    always @(posedge clk) begin
        obs_t e;
        obs_t got;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {isp_adjustment, ramp_busy, timeout_pulse, frame_count};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got isp=%h busy=%b pulse=%b fc=%0d expected isp=%h busy=%b pulse=%b fc=%0d",
                         $time, got.isp, got.busy, got.pulse, got.fc, e.isp, e.busy, e.pulse, e.fc);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic eof_beat(input bit rdy);
        mon_valid = 1'b1; mon_ready = rdy; mon_user = 8'h02;
        @(negedge clk);
        mon_valid = 1'b0; mon_ready = 1'b1; mon_user = 8'h00;
    endtask

    task automatic wr(input logic [7:0] t);
        cfg_target = t; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    initial begin
        int pulses;
        tick(3);
        chk("reset_isp", 16'(isp_adjustment), 16'h00);
        chk("reset_fc", frame_count, 16'd0);
        reset = 1'b0;

        // ramp up +40 by 16
        cfg_enable = 1'b1; cfg_step = 7'd16;
        wr(8'hA8); tick(1);
        eof_beat(1'b1); chk("up1", 16'(isp_adjustment), 16'h90); chk("up1_busy", 16'(ramp_busy), 16'd1);
        eof_beat(1'b1); chk("up2", 16'(isp_adjustment), 16'hA0);
        eof_beat(1'b1); chk("up3", 16'(isp_adjustment), 16'hA8); chk("up3_busy", 16'(ramp_busy), 16'd0);

        // down to -20 by 25, crossing zero
        cfg_step = 7'd25;
        wr(8'h14); tick(1);
        eof_beat(1'b1); chk("dn1", 16'(isp_adjustment), 16'h8F);
        eof_beat(1'b1); chk("dn2", 16'(isp_adjustment), 16'h0A);
        eof_beat(1'b1); chk("dn3", 16'(isp_adjustment), 16'h14);

        // step 0 jumps; unaccepted EOF ignored
        cfg_step = 7'd0;
        wr(8'hFF); tick(1);
        eof_beat(1'b1); chk("jump", 16'(isp_adjustment), 16'hFF);
        eof_beat(1'b0); chk("noacc_isp", 16'(isp_adjustment), 16'hFF); chk("noacc_fc", frame_count, 16'd7);

        // get to cur=0, then write collides with EOF
        cfg_enable = 1'b0; tick(1);
        eof_beat(1'b1); chk("zero", 16'(isp_adjustment), 16'h00);
        cfg_step = 7'd3; cfg_enable = 1'b1;
        wr(8'h8A); tick(1);
        cfg_target = 8'h85; cfg_we = 1'b1; mon_valid = 1'b1; mon_ready = 1'b1; mon_user = 8'h02;
        @(negedge clk);
        cfg_we = 1'b0; mon_valid = 1'b0; mon_user = 8'h00;
        chk("collide_old", 16'(isp_adjustment), 16'h83);
        eof_beat(1'b1); chk("collide_new", 16'(isp_adjustment), 16'h85);

        // watchdog snap
        cfg_step = 7'd1;
        wr(8'hFF);
        pulses = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (timeout_pulse) pulses++;
        end
        chk("to_pulses", 16'(pulses), 16'd1);
        chk("to_isp", 16'(isp_adjustment), 16'hFF);
        chk("to_busy", 16'(ramp_busy), 16'd0);

        // disable ramps back to pass-through, then reset mid-ramp
        cfg_step = 7'd0;
        wr(8'h94); tick(1);
        eof_beat(1'b1); chk("set20", 16'(isp_adjustment), 16'h94);
        cfg_step = 7'd8; cfg_enable = 1'b0; tick(1);
        eof_beat(1'b1); chk("off1", 16'(isp_adjustment), 16'h8C);
        eof_beat(1'b1); chk("off2", 16'(isp_adjustment), 16'h84);
        eof_beat(1'b1); chk("off3", 16'(isp_adjustment), 16'h00); chk("off3_busy", 16'(ramp_busy), 16'd0);
        cfg_enable = 1'b1;
        wr(8'hC0); tick(1);
        eof_beat(1'b1); chk("mid", 16'(isp_adjustment), 16'h88);
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        chk("rst_isp", 16'(isp_adjustment), 16'h00);
        chk("rst_busy", 16'(ramp_busy), 16'd0);
        chk("rst_fc", frame_count, 16'd0);

        // random traffic with occasional quiet stretches to hit the watchdog
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom % 600) == 0;
            cfg_we     = ($urandom % 10) == 0;
            cfg_target = 8'($urandom);
            if (($urandom % 20) == 0) cfg_step = ($urandom % 4 == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            if (($urandom % 40) == 0) cfg_enable = ($urandom % 4) != 0;
            if ((i % 700) > 560) begin
                mon_valid = 1'b0;
                mon_user  = 8'h00;
            end else begin
                mon_valid = ($urandom % 3) == 0;
                mon_user  = 8'($urandom);
            end
            mon_ready = ($urandom % 4) != 0;
            @(negedge clk);
        end
        reset = 1'b0; cfg_we = 1'b0; mon_valid = 1'b0;
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
